conv_mac_7: RTL and testbench

Weight-stream consumer for layer 7. Sits directly downstream of `weight_7`, whose coefficient FIFO it drains in lock-step with the layer-7 activation FIFO. Each pair is multiplied and accumulated over one kernel of `KERN_LEN` elements. The scaled, saturated dot product is then pushed to the next stage's FIFO, one result per kernel.

---
 rtl/conv_mac_7.sv | 121 ++++++++++++
 tb/tb_conv_mac_7.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_7.sv
// conv_mac_7: layer-7 weight/activation multiply-accumulate, one saturated result per kernel.
// Optional build macro CONV7_RELU_EN clamps negative results to zero.
module conv_mac_7 #(
    parameter int DATA_W   = 16,
    parameter int COEFF_W  = 16,
    parameter int ACC_W    = 40,
    parameter int KERN_LEN = 288,
    parameter int SHIFT    = 8,
    parameter int OUT_W    = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic signed [COEFF_W-1:0] weight_V_dout,
    input  logic                      weight_V_empty_n,
    output logic                      weight_V_read,
    input  logic signed [DATA_W-1:0]  input_V_dout,
    input  logic                      input_V_empty_n,
    output logic                      input_V_read,
    output logic signed [OUT_W-1:0]   output_V_din,
    input  logic                      output_V_full_n,
    output logic                      output_V_write
);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int CNT_W  = (KERN_LEN > 1) ? $clog2(KERN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERN_LEN - 1);

    typedef enum logic [1:0] {S_ACC, S_FLUSH, S_OUT} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_fire;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [PROD_W-1:0]  w_w_ext;
    logic signed [PROD_W-1:0]  w_a_ext;
    logic signed [PROD_W-1:0]  r_prod_p1;
    logic                      r_vld_p1;
    logic                      r_first_p1;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   r_acc_p2;
    logic signed [ACC_W-1:0]   w_shifted;

    // Clamp to the OUT_W signed range: in range iff all bits above OUT_W-1 match the sign.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [OUT_W-1:0] res;
        if (v[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){v[ACC_W-1]}})
            res = v[OUT_W-1:0];
        else if (v[ACC_W-1])
            res = {1'b1, {(OUT_W-1){1'b0}}};
        else
            res = {1'b0, {(OUT_W-1){1'b1}}};
        return res;
    endfunction

    function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v);
`ifdef CONV7_RELU_EN
        return v[OUT_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)
            r_state <= S_ACC;
        else
            r_state <= w_state_nxt;
    end

    // Both FIFOs pop together; reset gates the pop so nothing is consumed while held.
    always_comb begin
        w_state_nxt    = r_state;
        w_fire         = 1'b0;
        output_V_write = 1'b0;
        case (r_state)
            S_ACC: begin
                w_fire = weight_V_empty_n & input_V_empty_n & ~ap_rst;
                if (w_fire && (r_cnt == CNT_LAST))
                    w_state_nxt = S_FLUSH;
            end
            S_FLUSH: w_state_nxt = S_OUT;
            S_OUT: begin
                output_V_write = output_V_full_n & ~ap_rst;
                if (output_V_full_n)
                    w_state_nxt = S_ACC;
            end
            default: w_state_nxt = S_ACC;
        endcase
    end

    assign weight_V_read = w_fire;
    assign input_V_read  = w_fire;

    assign w_w_ext    = {{DATA_W{weight_V_dout[COEFF_W-1]}}, weight_V_dout};
    assign w_a_ext    = {{COEFF_W{input_V_dout[DATA_W-1]}}, input_V_dout};
    assign w_prod_ext = {{(ACC_W-PROD_W){r_prod_p1[PROD_W-1]}}, r_prod_p1};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_cnt      <= '0;
            r_prod_p1  <= '0;
            r_vld_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
            r_acc_p2   <= '0;
        end else begin
            // stage 1: product capture
            r_vld_p1 <= w_fire;
            if (w_fire) begin
                r_prod_p1  <= w_w_ext * w_a_ext;
                r_first_p1 <= (r_cnt == '0);
                r_cnt      <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
            // stage 2: accumulate, restarting on the first pair of a kernel
            if (r_vld_p1)
                r_acc_p2 <= (r_first_p1 ? '0 : r_acc_p2) + w_prod_ext;
        end
    end

    assign w_shifted    = r_acc_p2 >>> SHIFT;
    assign output_V_din = relu(sat_out(w_shifted));

endmodule

// File: tb/tb_conv_mac_7.sv
// Bench for conv_mac_7: FIFO model, table vectors, corner sequences and randomized kernels.
module tb_conv_mac_7;
    localparam int K = 4;
`ifdef CONV7_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic ap_clk = 1'b0;
    logic ap_rst;
    logic signed [15:0] weight_V_dout, input_V_dout;
    logic weight_V_empty_n, input_V_empty_n, output_V_full_n;
    logic weight_V_read, input_V_read, output_V_write;
    logic signed [15:0] output_V_din;
    logic weight8_read, input8_read, output8_write;
    logic signed [15:0] output8_din;

    always #5 ap_clk = ~ap_clk;

    conv_mac_7 #(.DATA_W(16), .COEFF_W(16), .ACC_W(40), .KERN_LEN(K), .SHIFT(0), .OUT_W(16)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .weight_V_dout(weight_V_dout), .weight_V_empty_n(weight_V_empty_n), .weight_V_read(weight_V_read),
        .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(input_V_read),
        .output_V_din(output_V_din), .output_V_full_n(output_V_full_n), .output_V_write(output_V_write));

    conv_mac_7 #(.DATA_W(16), .COEFF_W(16), .ACC_W(40), .KERN_LEN(K), .SHIFT(8), .OUT_W(16)) dut_s8 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .weight_V_dout(weight_V_dout), .weight_V_empty_n(weight_V_empty_n), .weight_V_read(weight8_read),
        .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(input8_read),
        .output_V_din(output8_din), .output_V_full_n(output_V_full_n), .output_V_write(output8_write));

    typedef struct packed {
        int w0; int w1; int w2; int w3;
        int a0; int a1; int a2; int a3;
        int e0; int e8;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic signed [15:0] wq[$];
    logic signed [15:0] aq[$];
    int expq[$];
    int expq8[$];
    int rd_cyc[$];
    int wr_cyc[$];
    bit wgate = 1'b1;
    bit agate = 1'b1;
    bit last_rd, last_wr;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        weight_V_empty_n = wgate && (wq.size() > 0);
        input_V_empty_n  = agate && (aq.size() > 0);
        weight_V_dout    = (wq.size() > 0) ? wq[0] : 16'sd0;
        input_V_dout     = (aq.size() > 0) ? aq[0] : 16'sd0;
    endtask

    task automatic tick();
        @(negedge ap_clk);
        last_rd = weight_V_read;
        last_wr = output_V_write;
        if (!ap_rst) begin
            chk("rd_lockstep", input_V_read, weight_V_read);
            chk("rd_needs_both", weight_V_read & ~(weight_V_empty_n & input_V_empty_n), 0);
            chk("s8_rd_same", weight8_read, weight_V_read);
            if (output_V_write) begin
                if (expq.size() == 0) chk("unexpected_write", output_V_write, 0);
                else chk("result", output_V_din, expq.pop_front());
                wr_cyc.push_back(cyc);
            end
            if (output8_write) begin
                if (expq8.size() == 0) chk("unexpected_write_s8", output8_write, 0);
                else chk("result_s8", output8_din, expq8.pop_front());
            end
            if (weight_V_read) rd_cyc.push_back(cyc);
        end
        @(posedge ap_clk);
        #1;
        if (last_rd) begin
            void'(wq.pop_front());
            void'(aq.pop_front());
        end
        cyc++;
        drive();
    endtask

    function automatic int model(input int w[K], input int a[K], input int sh);
        longint s = 0;
        for (int k = 0; k < K; k++) s += longint'(w[k]) * longint'(a[k]);
        s = s >>> sh;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (RELU && s < 0) s = 0;
        return int'(s);
    endfunction

    task automatic push_pair(input int w, input int a);
        wq.push_back(16'(w));
        aq.push_back(16'(a));
    endtask

    task automatic push_kernel(input int w[K], input int a[K]);
        for (int k = 0; k < K; k++) push_pair(w[k], a[k]);
        expq.push_back(model(w, a, 0));
        expq8.push_back(model(w, a, 8));
        drive();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((wq.size() > 0 || expq.size() > 0 || expq8.size() > 0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain", wq.size() + expq.size() + expq8.size(), 0);
    endtask

    function automatic int relu_exp(input int e);
        return (RELU && e < 0) ? 0 : e;
    endfunction

    initial begin
        int wv[K];
        int av[K];
        vec_t tbl[6];
        int n;

        // reset with data already waiting
        ap_rst = 1'b1;
        output_V_full_n = 1'b1;
        wv = '{1, 2, 3, 4};
        av = '{5, 6, 7, 8};
        push_kernel(wv, av);
        push_kernel(wv, av);
        @(negedge ap_clk);
        chk("rst_rd", weight_V_read, 0);
        chk("rst_wr", output_V_write, 0);
        chk("rst_din", output_V_din, 0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        drive();

        // back-to-back kernels
        rd_cyc.delete(); wr_cyc.delete();
        wait_idle(60);
        chk("b2b_nreads", rd_cyc.size(), 8);
        chk("b2b_nwrites", wr_cyc.size(), 2);
        if (rd_cyc.size() == 8 && wr_cyc.size() == 2) begin
            chk("b2b_consec", rd_cyc[3] - rd_cyc[0], 3);
            chk("b2b_latency", wr_cyc[0] - rd_cyc[3], 2);
            chk("b2b_resume", rd_cyc[4] - wr_cyc[0], 1);
        end

        // weight FIFO gap after pair 2
        rd_cyc.delete();
        push_kernel(wv, av);
        n = 0;
        while (rd_cyc.size() < 2 && n < 20) begin tick(); n++; end
        chk("gap_reach2", rd_cyc.size(), 2);
        wgate = 1'b0;
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_no_read", last_rd, 0);
        end
        wgate = 1'b1;
        drive();
        wait_idle(40);

        // back-pressure in S_OUT
        rd_cyc.delete(); wr_cyc.delete();
        output_V_full_n = 1'b0;
        push_kernel(wv, av);
        push_kernel(wv, av);
        n = 0;
        while (rd_cyc.size() < 4 && n < 20) begin tick(); n++; end
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_no_write", last_wr, 0);
            chk("bp_no_read", last_rd, 0);
            chk("bp_din_hold", output_V_din, 70);
        end
        output_V_full_n = 1'b1;
        tick();
        chk("bp_write", last_wr, 1);
        tick();
        chk("bp_single_write", wr_cyc.size(), 1);
        wait_idle(40);

        // reset mid-kernel
        rd_cyc.delete();
        push_pair(3, 3);
        push_pair(3, 3);
        drive();
        n = 0;
        while (rd_cyc.size() < 2 && n < 20) begin tick(); n++; end
        tick();
        chk("pre_rst_partial", output_V_din, 18);
        wv = '{1, 1, 1, 1};
        av = '{1, 1, 1, 1};
        push_kernel(wv, av);
        #2 ap_rst = 1'b1;
        @(negedge ap_clk);
        chk("mid_rst_rd", weight_V_read, 0);
        chk("mid_rst_wr", output_V_write, 0);
        chk("mid_rst_din", output_V_din, 0);
        chk("mid_rst_din_s8", output8_din, 0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        drive();
        wait_idle(40);

        // table vectors, streamed continuously
        tbl[0] = '{1, 2, 3, 4, 5, 6, 7, 8, 70, 0};
        tbl[1] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        tbl[2] = '{-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767, -32768, -32768};
        tbl[3] = '{-1, 2, -3, 4, 100, 200, 300, 400, 1000, 3};
        tbl[4] = '{-5, 0, 0, 0, 1, 1, 1, 1, -5, -1};
        tbl[5] = '{7, -7, 7, -7, 1, 1, 1, 1, 0, 0};
        wr_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            push_pair(tbl[i].w0, tbl[i].a0);
            push_pair(tbl[i].w1, tbl[i].a1);
            push_pair(tbl[i].w2, tbl[i].a2);
            push_pair(tbl[i].w3, tbl[i].a3);
            expq.push_back(relu_exp(tbl[i].e0));
            expq8.push_back(relu_exp(tbl[i].e8));
        end
        drive();
        wait_idle(200);
        chk("tbl_nwrites", wr_cyc.size(), 6);

        // randomized kernels with random FIFO availability and back-pressure
        for (int kk = 0; kk < 25; kk++) begin
            for (int k = 0; k < K; k++) begin
                if (kk % 2 == 0) begin
                    wv[k] = int'($urandom_range(0, 65535)) - 32768;
                    av[k] = int'($urandom_range(0, 65535)) - 32768;
                end else begin
                    wv[k] = int'($urandom_range(0, 200)) - 100;
                    av[k] = int'($urandom_range(0, 200)) - 100;
                end
            end
            push_kernel(wv, av);
        end
        n = 0;
        while ((wq.size() > 0 || expq.size() > 0) && n < 3000) begin
            wgate = ($urandom_range(0, 3) != 0);
            agate = ($urandom_range(0, 3) != 0);
            output_V_full_n = ($urandom_range(0, 3) != 0);
            drive();
            tick();
            n++;
        end
        wgate = 1'b1;
        agate = 1'b1;
        output_V_full_n = 1'b1;
        drive();
        wait_idle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end
endmodule
